slow_tick_timer: RTL and testbench

- Consumer of the divided slow clock (`sclk`) produced by the clock divider, sampled as data in the single system clock domain.
- Synchronises `sclk`, turns each rising edge into a one-cycle tick, and counts ticks.
- Raises a compare-match interrupt for the RISC-V core, with auto-reload or one-shot operation.
- Also drives visible blink/timing status for LEDs and debug.

---
 rtl/timer_pkg.sv | 16 +
 rtl/slow_tick_timer_edge_sync.sv | 27 ++
 rtl/slow_tick_timer.sv | 90 +++++++++
 tb/tb_slow_tick_timer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared state encoding and default sizing for the slow tick timer.
package timer_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam int DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_HALT = ST_HALT
   } tmr_state_e;

endpackage

// File: rtl/slow_tick_timer_edge_sync.sv
// Synchronises an asynchronous level and emits a registered one-cycle pulse per rising edge.
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // All history resets high so a level already high at reset is not seen as an edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q     <= '1;
         prev_q     <= 1'b1;
         rise_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q     <= sync_q[SYNC_STAGES-1];
         rise_pulse <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

endmodule

// File: rtl/slow_tick_timer.sv
// Counts synchronised slow-clock ticks and raises a compare-match interrupt
// in periodic (auto-reload) or one-shot mode, with sticky overflow/missed flags.
module slow_tick_timer
   import timer_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclk_in,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] cmp_val,
   input  logic             auto_reload,
   input  logic             irq_ack,
   output logic             tick,
   output logic [WIDTH-1:0] count,
   output logic             irq,
   output logic             overflow,
   output logic             missed,
   output logic [1:0]       state
);

   tmr_state_e st_q;
   logic       match;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (sclk_in),
      .rise_pulse (tick)
   );

   // A load in the same cycle swallows the tick, so it can never match.
   always_comb begin
      match = 1'b0;
      if (en && (st_q == S_RUN) && tick && !load && (count == cmp_val))
         match = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q     <= S_IDLE;
         count    <= '0;
         irq      <= 1'b0;
         overflow <= 1'b0;
         missed   <= 1'b0;
      end else begin
         if (match) begin
            irq <= 1'b1;
            if (irq && !irq_ack)
               missed <= 1'b1;
         end else if (irq_ack) begin
            irq <= 1'b0;
         end

         if (load) begin
            count    <= load_val;
            overflow <= 1'b0;
            missed   <= 1'b0;
         end

         if (!en) begin
            st_q <= S_IDLE;
         end else begin
            case (st_q)
               S_IDLE: if (!load) st_q <= S_RUN;
               S_RUN: begin
                  if (tick && !load) begin
                     if (count == cmp_val) begin
                        if (auto_reload) count <= '0;
                        else             st_q  <= S_HALT;
                     end else begin
                        count <= count + 1'b1;
                        if (&count) overflow <= 1'b1;
                     end
                  end
               end
               S_HALT: if (load) st_q <= S_RUN;
               default: st_q <= S_IDLE;
            endcase
         end
      end
   end

   assign state = st_q;

endmodule

// File: tb/tb_slow_tick_timer.sv
// Randomised scoreboard bench for slow_tick_timer: a 32-bit and a 4-bit instance
// share stimulus and are checked every cycle against a spec-level reference model.
module tb_slow_tick_timer;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk_in = 1'b1;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [31:0] load_val = '0;
   logic [31:0] cmp_val = '0;
   logic        auto_reload = 1'b0;
   logic        irq_ack = 1'b0;

   logic        tick0, irq0, ovf0, mis0;
   logic [31:0] cnt0;
   logic [1:0]  st0;
   logic        tick1, irq1, ovf1, mis1;
   logic [3:0]  cnt1;
   logic [1:0]  st1;

   always #5 clk = ~clk;

   slow_tick_timer #(.WIDTH(32), .SYNC_STAGES(S)) dut32 (
      .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .en(en), .load(load),
      .load_val(load_val), .cmp_val(cmp_val), .auto_reload(auto_reload),
      .irq_ack(irq_ack), .tick(tick0), .count(cnt0), .irq(irq0),
      .overflow(ovf0), .missed(mis0), .state(st0)
   );

   slow_tick_timer #(.WIDTH(4), .SYNC_STAGES(S)) dut4 (
      .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .en(en), .load(load),
      .load_val(load_val[3:0]), .cmp_val(cmp_val[3:0]), .auto_reload(auto_reload),
      .irq_ack(irq_ack), .tick(tick1), .count(cnt1), .irq(irq1),
      .overflow(ovf1), .missed(mis1), .state(st1)
   );

   typedef struct packed {
      logic        tick;
      logic [31:0] count;
      logic        irq;
      logic        ovf;
      logic        mis;
      logic [1:0]  st;
   } obs_t;

   obs_t q0[$];
   obs_t q1[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model state (spec-level: IDLE=0, RUN=1, HALT=2)
   bit          hist[$];
   logic        m_tick;
   logic [31:0] m_count[2];
   logic [1:0]  m_st[2];
   logic        m_irq[2], m_ovf[2], m_mis[2];
   logic [31:0] mask[2];

   task automatic model_edge();
      logic new_tick;
      logic [31:0] cmpm;
      logic t, hit;
      obs_t o;
      if (!rst_n) begin
         hist.delete();
         for (int k = 0; k < S + 2; k++) hist.push_back(1'b1);
         new_tick = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_count[i] = '0; m_st[i] = 2'd0;
            m_irq[i] = 1'b0; m_ovf[i] = 1'b0; m_mis[i] = 1'b0;
         end
      end else begin
         hist.push_back(sclk_in);
         new_tick = hist[hist.size()-1-S] & ~hist[hist.size()-2-S];
         void'(hist.pop_front());
         for (int i = 0; i < 2; i++) begin
            cmpm = cmp_val & mask[i];
            t    = m_tick && !load;
            hit  = en && (m_st[i] == 2'd1) && t && (m_count[i] == cmpm);
            if (hit) begin
               if (m_irq[i] && !irq_ack) m_mis[i] = 1'b1;
               m_irq[i] = 1'b1;
            end else if (irq_ack) m_irq[i] = 1'b0;
            if (load) begin
               m_count[i] = load_val & mask[i];
               m_ovf[i] = 1'b0;
               m_mis[i] = 1'b0;
            end
            if (!en) m_st[i] = 2'd0;
            else if (m_st[i] == 2'd0) begin
               if (!load) m_st[i] = 2'd1;
            end else if (m_st[i] == 2'd1) begin
               if (t) begin
                  if (hit) begin
                     if (auto_reload) m_count[i] = 0;
                     else m_st[i] = 2'd2;
                  end else begin
                     if (m_count[i] == mask[i]) m_ovf[i] = 1'b1;
                     m_count[i] = (m_count[i] + 1) & mask[i];
                  end
               end
            end else if (load) m_st[i] = 2'd1;
         end
      end
      m_tick = new_tick;
      for (int i = 0; i < 2; i++) begin
         o.tick = m_tick; o.count = m_count[i]; o.irq = m_irq[i];
         o.ovf = m_ovf[i]; o.mis = m_mis[i]; o.st = m_st[i];
         if (i == 0) q0.push_back(o); else q1.push_back(o);
      end
   endtask

   // sclk generator: random high/low lengths within [smin,smax] clk periods
   int  s_cnt = 4;
   int  smin = 2, smax = 6;
   bit  s_hold = 1'b1;

   task automatic sclk_gen();
      if (s_hold) return;
      if (s_cnt <= 1) begin
         sclk_in = ~sclk_in;
         s_cnt = $urandom_range(smax, smin);
      end else s_cnt--;
   endtask

   task automatic cycle();
      sclk_gen();
      model_edge();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      obs_t e;
      #1;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         chk("w32.tick", {31'd0, tick0}, {31'd0, e.tick});
         chk("w32.count", cnt0, e.count);
         chk("w32.irq", {31'd0, irq0}, {31'd0, e.irq});
         chk("w32.overflow", {31'd0, ovf0}, {31'd0, e.ovf});
         chk("w32.missed", {31'd0, mis0}, {31'd0, e.mis});
         chk("w32.state", {30'd0, st0}, {30'd0, e.st});
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         chk("w4.tick", {31'd0, tick1}, {31'd0, e.tick});
         chk("w4.count", {28'd0, cnt1}, e.count);
         chk("w4.irq", {31'd0, irq1}, {31'd0, e.irq});
         chk("w4.overflow", {31'd0, ovf1}, {31'd0, e.ovf});
         chk("w4.missed", {31'd0, mis1}, {31'd0, e.mis});
         chk("w4.state", {30'd0, st1}, {30'd0, e.st});
      end
   end

   initial begin
      mask[0] = 32'hFFFF_FFFF;
      mask[1] = 32'h0000_000F;
      m_tick = 1'b0;
      @(negedge clk);

      // Reset held with sclk high, then sclk stays high: no tick may appear
      rst_n = 1'b0; sclk_in = 1'b1; s_hold = 1'b1;
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (10) cycle();

      // Periodic mode, fixed 4/4 slow clock, cmp=3, one ack mid-run
      en = 1'b1; auto_reload = 1'b1; cmp_val = 32'd3;
      s_hold = 1'b0; smin = 4; smax = 4; s_cnt = 1; sclk_in = 1'b1;
      for (int c = 0; c < 60; c++) begin
         irq_ack = (c == 45);
         cycle();
      end
      irq_ack = 1'b0;

      // One-shot, cmp=2, run into HALT then reload from 0
      auto_reload = 1'b0; cmp_val = 32'd2;
      load = 1'b1; load_val = 32'd0; cycle(); load = 1'b0;
      repeat (80) cycle();
      load = 1'b1; load_val = 32'd0; cycle(); load = 1'b0;
      repeat (20) cycle();

      // Wrap through all-ones on both widths
      auto_reload = 1'b1; cmp_val = 32'd2;
      load = 1'b1; load_val = 32'hFFFF_FFFE; cycle(); load = 1'b0;
      repeat (50) cycle();

      // Randomised mix of enable drops, loads, acks, mode and compare changes
      smin = 1; smax = 6;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(30, 0) == 0) en = ~en;
         if (!en && $urandom_range(4, 0) == 0) en = 1'b1;
         if ($urandom_range(60, 0) == 0) auto_reload = ~auto_reload;
         if ($urandom_range(40, 0) == 0) cmp_val = $urandom_range(7, 0);
         load = ($urandom_range(25, 0) == 0);
         if ($urandom_range(3, 0) == 0) load_val = 32'hFFFF_FFFC + $urandom_range(3, 0);
         else load_val = $urandom_range(10, 0);
         irq_ack = ($urandom_range(5, 0) == 0);
         if (c == 3000) rst_n = 1'b0;
         if (c == 3002) rst_n = 1'b1;
         cycle();
      end
      load = 1'b0; irq_ack = 1'b0;
      repeat (3) cycle();
      @(posedge clk); #2;

      n_cmp++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard.drain: got %0d/%0d entries left, expected 0", q0.size(), q1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
